gps_lbll_key_loader: RTL and testbench

Upstream key-delivery stage for the locked GPS core (gps_lbll). It receives the latch-locking key as a byte stream with a valid/ready handshake, followed by one checksum byte. On a good checksum it commits the full key atomically onto lbll_key. Until a good commit, the locked core sees all-zero key bits. A session that fails the checksum or times out leaves the previously committed key in place.

---
 rtl/gps_lbll_key_loader.sv | 125 ++++++++++++
 tb/tb_gps_lbll_key_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gps_lbll_key_loader.sv
// Key-delivery front end for the locked GPS core: collects the key as a byte stream, verifies an
// XOR checksum byte, and commits the whole key to lbll_key in a single cycle.
module gps_lbll_key_loader #(
  parameter int unsigned NBITS   = 256,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic             sys_clk_50,
  input  logic             sync_rst_in,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [NBITS-1:0] lbll_key,
  output logic             key_valid,
  output logic             key_error,
  output logic             busy
);

  localparam int unsigned NBYTES = NBITS / 8;
  localparam int unsigned CntW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned TmoW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(NBYTES - 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StShift, StCheck} state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] key_q, key_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [TmoW-1:0]  tmo_q, tmo_d;
  logic [7:0]       csum_q, csum_d;
  logic             key_valid_q, key_valid_d;
  logic             key_error_q, key_error_d;
  logic             accept;

  assign byte_ready = (state_q != StIdle);
  assign busy       = byte_ready;
  assign accept     = byte_valid & byte_ready;
  assign lbll_key   = key_q;
  assign key_valid  = key_valid_q;
  assign key_error  = key_error_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    key_d       = key_q;
    count_d     = count_q;
    tmo_d       = tmo_q;
    csum_d      = csum_q;
    key_valid_d = key_valid_q;
    key_error_d = key_error_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StShift;
          shift_d     = '0;
          count_d     = '0;
          csum_d      = '0;
          tmo_d       = '0;
          key_error_d = 1'b0;
        end
      end
      StShift: begin
        if (accept) begin
          // Truncating cast drops the oldest byte; also valid when NBITS == 8.
          shift_d = NBITS'({shift_q, byte_in});
          csum_d  = csum_q ^ byte_in;
          count_d = count_q + 1'b1;
          tmo_d   = '0;
          if (count_q == LastCnt) begin
            state_d = StCheck;
          end
        end else if (tmo_q == TmoLast) begin
          state_d     = StIdle;
          key_error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StCheck: begin
        if (accept) begin
          state_d = StIdle;
          tmo_d   = '0;
          if (byte_in == csum_q) begin
            key_d       = shift_q;
            key_valid_d = 1'b1;
          end else begin
            key_error_d = 1'b1;
          end
        end else if (tmo_q == TmoLast) begin
          state_d     = StIdle;
          key_error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk_50 or posedge sync_rst_in) begin
    if (sync_rst_in) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      key_q       <= '0;
      count_q     <= '0;
      tmo_q       <= '0;
      csum_q      <= '0;
      key_valid_q <= 1'b0;
      key_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      key_q       <= key_d;
      count_q     <= count_d;
      tmo_q       <= tmo_d;
      csum_q      <= csum_d;
      key_valid_q <= key_valid_d;
      key_error_q <= key_error_d;
    end
  end

endmodule

// File: tb/tb_gps_lbll_key_loader.sv
// Directed bench for gps_lbll_key_loader: scoreboarded sessions covering commit, bad checksum,
// timeout, throttled delivery and asynchronous reset.
module tb_gps_lbll_key_loader;

  localparam int unsigned NBITS   = 256;
  localparam int unsigned TIMEOUT = 1024;
  localparam int unsigned NBYTES  = NBITS / 8;
  localparam logic [NBITS-1:0] NomKey =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic             sys_clk_50 = 1'b0;
  logic             sync_rst_in;
  logic             start;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic [NBITS-1:0] lbll_key;
  logic             key_valid;
  logic             key_error;
  logic             busy;

  gps_lbll_key_loader #(
    .NBITS  (NBITS),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk_50 (sys_clk_50),
    .sync_rst_in(sync_rst_in),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .lbll_key   (lbll_key),
    .key_valid  (key_valid),
    .key_error  (key_error),
    .busy       (busy)
  );

  always #5 sys_clk_50 = ~sys_clk_50;

  typedef struct {
    logic [NBITS-1:0] key;
    logic             valid;
    logic             err;
  } exp_t;

  exp_t             sb[$];
  int               n_cmp = 0;
  int               n_bad = 0;
  logic [7:0]       pay[NBYTES];
  logic [NBITS-1:0] m_key;
  logic             m_valid;

  task automatic check(input string tag, input logic [NBITS-1:0] obs,
                       input logic [NBITS-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk_50);
    #1;
  endtask

  // Idle cycles with byte_valid low; optionally pulse start to prove it is ignored while busy.
  task automatic gap(input int n, input bit pulse);
    byte_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      start = pulse;
      tick();
    end
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_err_clr", key_error, 0);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    n_cmp++;
    assert (sb.size() != 0) else begin
      n_bad++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_key"}, lbll_key, e.key);
      check({tag, "_valid"}, key_valid, e.valid);
      check({tag, "_err"}, key_error, e.err);
      check({tag, "_busy"}, busy, 0);
    end
  endtask

  task automatic run_session(input string tag, input logic [7:0] cs, input bit throttle);
    logic [7:0]       x;
    logic [NBITS-1:0] k;
    exp_t             e;
    start_session();
    x = '0;
    k = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (throttle) gap(($urandom_range(0, 7) == 0) ? $urandom_range(10, 60)
                                                      : $urandom_range(0, 2), 1'b1);
      if (i == NBYTES / 2) begin
        check({tag, "_mid_key"}, lbll_key, m_key);
        check({tag, "_mid_valid"}, key_valid, m_valid);
      end
      send_byte(pay[i]);
      x ^= pay[i];
      k = NBITS'({k, pay[i]});
    end
    if (cs == x) begin
      e.key = k; e.valid = 1'b1; e.err = 1'b0;
      m_key = k; m_valid = 1'b1;
    end else begin
      e.key = m_key; e.valid = m_valid; e.err = 1'b1;
    end
    sb.push_back(e);
    if (throttle) gap($urandom_range(1, 20), 1'b1);
    send_byte(cs);
    pop_check(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    sync_rst_in = 1'b1;
    start       = 1'b0;
    byte_in     = '0;
    byte_valid  = 1'b0;
    m_key       = '0;
    m_valid     = 1'b0;
    #12;
    check("rst_key", lbll_key, 0);
    check("rst_valid", key_valid, 0);
    check("rst_err", key_error, 0);
    check("rst_ready", byte_ready, 0);
    check("rst_busy", busy, 0);
    sync_rst_in = 1'b0;
    tick();

    // Nominal commit, checksum of 0x00..0x1F is 0x00.
    for (int i = 0; i < NBYTES; i++) pay[i] = 8'(i);
    run_session("nominal", 8'h00, 1'b0);
    check("nominal_literal", lbll_key, NomKey);

    // Bad checksum: 32 x 0xFF folds to 0x00, send 0x01.
    for (int i = 0; i < NBYTES; i++) pay[i] = 8'hff;
    run_session("badcsum", 8'h01, 1'b0);
    check("badcsum_literal", lbll_key, NomKey);

    // Timeout after 10 accepted bytes.
    start_session();
    for (int i = 0; i < 10; i++) send_byte(8'(8'ha0 + i));
    e.key = m_key; e.valid = m_valid; e.err = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("tmo_still_busy", busy, 1);
    tick();
    pop_check("timeout");

    // byte_valid in IDLE is not consumed.
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    tick();
    check("idle_ready", byte_ready, 0);
    tick();
    byte_valid = 1'b0;
    check("idle_no_session", busy, 0);

    // Throttled delivery with start pulsed while busy.
    for (int i = 0; i < NBYTES; i++) pay[i] = 8'(i);
    run_session("throttled", 8'h00, 1'b1);
    check("throttled_literal", lbll_key, NomKey);
    tick();
    check("no_restart", busy, 0);

    // Asynchronous reset between edges during byte 5.
    start_session();
    for (int i = 0; i < 4; i++) send_byte(8'(i));
    byte_in    = 8'h04;
    byte_valid = 1'b1;
    #3;
    sync_rst_in = 1'b1;
    #1;
    check("arst_key", lbll_key, 0);
    check("arst_valid", key_valid, 0);
    check("arst_ready", byte_ready, 0);
    check("arst_err", key_error, 0);
    byte_valid = 1'b0;
    m_key      = '0;
    m_valid    = 1'b0;
    tick();
    #3;
    sync_rst_in = 1'b0;
    tick();
    check("post_rst_idle", busy, 0);

    // Recovery: a fresh session commits normally.
    run_session("recover", 8'h00, 1'b0);
    check("recover_literal", lbll_key, NomKey);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
